// File: rtl/div_unit_pkg.sv
// Shared definitions for the multi-cycle divider: state encodings, handshake
// levels and bus widths used by div_unit and its EX-stage requester.
package div_unit_pkg;

    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

    localparam logic DivSigned   = 1'b1;
    localparam logic DivUnsigned = 1'b0;

    localparam int DOUBLE_REG_BUS_W = 64;

endpackage

// File: rtl/div_unit.sv
// Radix-2 restoring divider: one quotient bit per cycle, returns
// {remainder, quotient} with remainder taking the dividend's sign.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);

    div_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH:0]   dividend_q, dividend_d;
    logic [WIDTH-1:0]   divisor_q, divisor_d;
    logic               signed_q, signed_d;
    logic               sign1_q, sign1_d;
    logic               sign2_q, sign2_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               ready_q, ready_d;

    logic [WIDTH-1:0]   op1_mag;
    logic [WIDTH-1:0]   op2_mag;
    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    // The most negative value negates to itself, which read unsigned is its magnitude.
    assign op1_mag = (signed_div_i && opdata1_i[WIDTH-1]) ? (~opdata1_i + 1'b1) : opdata1_i;
    assign op2_mag = (signed_div_i && opdata2_i[WIDTH-1]) ? (~opdata2_i + 1'b1) : opdata2_i;

    // Bit WIDTH of the trial difference is the borrow: set means "does not fit".
    assign trial = {1'b0, dividend_q[2*WIDTH-1:WIDTH]} - {1'b0, divisor_q};

    always_comb begin
        quot_fix = dividend_q[WIDTH-1:0];
        rem_fix  = dividend_q[2*WIDTH:WIDTH+1];
        if (signed_q && (sign1_q ^ sign2_q)) begin
            quot_fix = ~dividend_q[WIDTH-1:0] + 1'b1;
        end
        if (signed_q && sign1_q) begin
            rem_fix = ~dividend_q[2*WIDTH:WIDTH+1] + 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        signed_d   = signed_q;
        sign1_d    = sign1_q;
        sign2_d    = sign2_q;
        result_d   = result_q;
        ready_d    = ready_q;

        case (state_q)
            DIV_FREE: begin
                ready_d  = DivResultNotReady;
                result_d = '0;
                if (start_i == DivStart && !annul_i) begin
                    signed_d  = signed_div_i;
                    sign1_d   = opdata1_i[WIDTH-1];
                    sign2_d   = opdata2_i[WIDTH-1];
                    divisor_d = op2_mag;
                    if (opdata2_i == '0) begin
                        state_d = DIV_BYZERO;
                    end else begin
                        dividend_d = {{WIDTH{1'b0}}, op1_mag, 1'b0};
                        cnt_d      = '0;
                        state_d    = DIV_ON;
                    end
                end
            end
            DIV_BYZERO: begin
                if (annul_i) begin
                    state_d = DIV_FREE;
                end else begin
                    dividend_d = '0;
                    state_d    = DIV_END;
                end
            end
            DIV_ON: begin
                if (annul_i) begin
                    state_d = DIV_FREE;
                end else if (cnt_q != CNT_W'(WIDTH)) begin
                    if (trial[WIDTH]) begin
                        dividend_d = {dividend_q[2*WIDTH-1:0], 1'b0};
                    end else begin
                        dividend_d = {trial[WIDTH-1:0], dividend_q[WIDTH-1:0], 1'b1};
                    end
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    dividend_d = {rem_fix, dividend_q[WIDTH], quot_fix};
                    cnt_d      = '0;
                    state_d    = DIV_END;
                end
            end
            DIV_END: begin
                // Result is committed here; a late annul no longer applies.
                result_d = {dividend_q[2*WIDTH:WIDTH+1], dividend_q[WIDTH-1:0]};
                ready_d  = DivResultReady;
                if (start_i == DivStop) begin
                    state_d  = DIV_FREE;
                    ready_d  = DivResultNotReady;
                    result_d = '0;
                end
            end
            default: begin
                state_d = DIV_FREE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= DIV_FREE;
            cnt_q      <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            signed_q   <= 1'b0;
            sign1_q    <= 1'b0;
            sign2_q    <= 1'b0;
            result_q   <= '0;
            ready_q    <= DivResultNotReady;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            signed_q   <= signed_d;
            sign1_q    <= sign1_d;
            sign2_q    <= sign2_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule
